// File: rtl/ex_trap_arb.sv
// ex_trap_arb: synchronizes external interrupt lines, turns rising edges into
// pending bits, and offers the lowest enabled pending line to the core through
// a valid/ready trap handshake.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | no offer; waiting for an enabled pending line
//   S_REQ  | offering trap_id_o; held stable until valid & ready
//   S_GAP  | one forced idle cycle after a handshake
module ex_trap_arb #(
    parameter int IRQ_NUM = 8,
    parameter int ID_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [IRQ_NUM-1:0] irq_i,
    input  logic [IRQ_NUM-1:0] irq_mask_i,
    output logic               core_ex_trap_valid,
    input  logic               core_ex_trap_ready,
    output logic [ID_W-1:0]    trap_id_o,
    output logic [IRQ_NUM-1:0] pending_o,
    output logic               lost_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IRQ_NUM-1:0] r_sync1;
    logic [IRQ_NUM-1:0] r_sync2;
    logic [IRQ_NUM-1:0] r_sync2_d;
    logic [IRQ_NUM-1:0] r_pending;
    logic               r_lost;
    logic [ID_W-1:0]    r_trap_id;

    logic [IRQ_NUM-1:0] w_edge;
    logic [IRQ_NUM-1:0] w_cand;
    logic [IRQ_NUM-1:0] w_clr;
    logic               w_hs;
    logic               w_offer;
    logic [ID_W-1:0]    w_sel_id;

    assign w_edge  = r_sync2 & ~r_sync2_d;
    assign w_cand  = r_pending & irq_mask_i;
    assign w_hs    = (r_state == S_REQ) && core_ex_trap_ready;
    assign w_offer = (r_state == S_IDLE) && (|w_cand);

    // Two-flop synchronizer plus the delayed copy used for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sync2_d <= '0;
        end else begin
            r_sync1   <= irq_i;
            r_sync2   <= r_sync1;
            r_sync2_d <= r_sync2;
        end
    end

    // One-hot clear mask for the line being accepted this cycle.
    always_comb begin
        w_clr = '0;
        for (int i = 0; i < IRQ_NUM; i++) begin
            w_clr[i] = w_hs && (r_trap_id == ID_W'(i));
        end
    end

    // Lowest-index enabled pending line; descending scan so index 0 wins.
    always_comb begin
        w_sel_id = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_sel_id = ID_W'(i);
            end
        end
    end

    // Pending bits: a new edge wins over the handshake clear of the same line;
    // an edge on a line already pending (and not being cleared) is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_lost    <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_edge;
            if (|(w_edge & r_pending & ~w_clr)) begin
                r_lost <= 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; the mask is only consulted in S_IDLE so an offer
    // in flight cannot be withdrawn.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_offer) w_state_nxt = S_REQ;
            S_REQ:   if (w_hs)    w_state_nxt = S_GAP;
            S_GAP:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Offered id is captured on entry to S_REQ and held until the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_trap_id <= '0;
        end else if (w_offer) begin
            r_trap_id <= w_sel_id;
        end
    end

    assign core_ex_trap_valid = (r_state == S_REQ);
    assign trap_id_o          = r_trap_id;
    assign pending_o          = r_pending;
    assign lost_o             = r_lost;

endmodule

// File: tb/tb_ex_trap_arb.sv
// Directed testbench for ex_trap_arb with hand-computed expectations.
module tb_ex_trap_arb;

    logic       clk;
    logic       rst;
    logic [7:0] irq_i;
    logic [7:0] irq_mask_i;
    logic       core_ex_trap_valid;
    logic       core_ex_trap_ready;
    logic [2:0] trap_id_o;
    logic [7:0] pending_o;
    logic       lost_o;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

    ex_trap_arb #(.IRQ_NUM(8), .ID_W(3)) dut (
        .clk                (clk),
        .rst                (rst),
        .irq_i              (irq_i),
        .irq_mask_i         (irq_mask_i),
        .core_ex_trap_valid (core_ex_trap_valid),
        .core_ex_trap_ready (core_ex_trap_ready),
        .trap_id_o          (trap_id_o),
        .pending_o          (pending_o),
        .lost_o             (lost_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; return 1 time unit after the last one.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        irq_i = 8'h00;
        irq_mask_i = 8'hFF;
        core_ex_trap_ready = 1'b0;
        step(3);
        chk("rst_valid", 32'(core_ex_trap_valid), 0);
        chk("rst_id", 32'(trap_id_o), 0);
        chk("rst_pending", 32'(pending_o), 0);
        chk("rst_lost", 32'(lost_o), 0);
        rst = 1'b0;
        step(2);

        // Single line 5, 20-cycle pulse, ready tied high.
        core_ex_trap_ready = 1'b1;
        irq_i = 8'h20;
        step(2);
        chk("t1_pend_e1", 32'(pending_o), 32'h00);
        step(1);
        chk("t1_pend_e2", 32'(pending_o), 32'h20);
        chk("t1_valid_e2", 32'(core_ex_trap_valid), 0);
        step(1);
        chk("t1_valid_e3", 32'(core_ex_trap_valid), 1);
        chk("t1_id", 32'(trap_id_o), 5);
        step(1);
        chk("t1_valid_gap", 32'(core_ex_trap_valid), 0);
        chk("t1_pend_clr", 32'(pending_o), 32'h00);
        cnt = 0;
        for (int k = 0; k < 15; k++) begin
            step(1);
            if (core_ex_trap_valid) cnt++;
        end
        irq_i = 8'h00;
        for (int k = 0; k < 6; k++) begin
            step(1);
            if (core_ex_trap_valid) cnt++;
        end
        chk("t1_no_second", 32'(cnt), 0);
        chk("t1_pend_end", 32'(pending_o), 32'h00);

        // Lines 6 and 2 together: id 2 first, then id 6.
        irq_i = 8'h44;
        step(3);
        chk("t2_pend", 32'(pending_o), 32'h44);
        step(1);
        chk("t2_valid_a", 32'(core_ex_trap_valid), 1);
        chk("t2_id_a", 32'(trap_id_o), 2);
        step(1);
        chk("t2_gap_valid", 32'(core_ex_trap_valid), 0);
        chk("t2_gap_pend", 32'(pending_o), 32'h40);
        step(1);
        chk("t2_idle_valid", 32'(core_ex_trap_valid), 0);
        step(1);
        chk("t2_valid_b", 32'(core_ex_trap_valid), 1);
        chk("t2_id_b", 32'(trap_id_o), 6);
        step(1);
        chk("t2_pend_end", 32'(pending_o), 32'h00);
        irq_i = 8'h00;
        step(4);

        // Masked pending line 3 waits until enabled.
        irq_mask_i = 8'h00;
        irq_i = 8'h08;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (core_ex_trap_valid) cnt++;
        end
        chk("t3_masked_valid", 32'(cnt), 0);
        chk("t3_masked_pend", 32'(pending_o), 32'h08);
        irq_mask_i = 8'h08;
        step(1);
        chk("t3_valid", 32'(core_ex_trap_valid), 1);
        chk("t3_id", 32'(trap_id_o), 3);
        step(1);
        chk("t3_pend_end", 32'(pending_o), 32'h00);
        irq_i = 8'h00;
        irq_mask_i = 8'hFF;
        step(4);

        // Stall: id 4 held while mask drops and line 1 arrives.
        core_ex_trap_ready = 1'b0;
        irq_i = 8'h10;
        step(4);
        chk("t4_valid", 32'(core_ex_trap_valid), 1);
        chk("t4_id", 32'(trap_id_o), 4);
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            if (k == 10) begin
                irq_mask_i = 8'h00;
                irq_i = 8'h12;
            end
            step(1);
            if (!(core_ex_trap_valid === 1'b1 && trap_id_o === 3'd4)) cnt++;
        end
        chk("t4_held", 32'(cnt), 0);
        chk("t4_pend", 32'(pending_o), 32'h12);
        core_ex_trap_ready = 1'b1;
        step(1);
        chk("t4_done_valid", 32'(core_ex_trap_valid), 0);
        chk("t4_done_pend", 32'(pending_o), 32'h02);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step(1);
            if (core_ex_trap_valid) cnt++;
        end
        chk("t4_line1_masked", 32'(cnt), 0);
        chk("t4_line1_pend", 32'(pending_o), 32'h02);
        irq_mask_i = 8'hFF;
        step(6);
        chk("t4_flush", 32'(pending_o), 32'h00);
        irq_i = 8'h00;
        step(4);

        // Edge on line 0 landing exactly in its handshake-clear cycle.
        core_ex_trap_ready = 1'b0;
        irq_i = 8'h01;
        step(4);
        chk("t5_valid", 32'(core_ex_trap_valid), 1);
        chk("t5_id", 32'(trap_id_o), 0);
        irq_i = 8'h00;
        step(3);
        irq_i = 8'h01;
        step(2);
        core_ex_trap_ready = 1'b1;
        step(1);
        chk("t5_coll_valid", 32'(core_ex_trap_valid), 0);
        chk("t5_coll_pend", 32'(pending_o), 32'h01);
        chk("t5_coll_lost", 32'(lost_o), 0);
        step(2);
        chk("t5_reoffer_valid", 32'(core_ex_trap_valid), 1);
        chk("t5_reoffer_id", 32'(trap_id_o), 0);
        step(1);
        chk("t5_end_pend", 32'(pending_o), 32'h00);
        chk("t5_end_lost", 32'(lost_o), 0);

        // Second edge on line 0 while still pending sets lost_o.
        core_ex_trap_ready = 1'b0;
        irq_i = 8'h00;
        step(3);
        irq_i = 8'h01;
        step(4);
        chk("t6_valid", 32'(core_ex_trap_valid), 1);
        chk("t6_lost_before", 32'(lost_o), 0);
        irq_i = 8'h00;
        step(3);
        irq_i = 8'h01;
        step(3);
        chk("t6_lost", 32'(lost_o), 1);
        core_ex_trap_ready = 1'b1;
        step(6);
        chk("t6_pend_end", 32'(pending_o), 32'h00);
        chk("t6_lost_sticky", 32'(lost_o), 1);
        irq_i = 8'h00;
        step(4);

        // Reset during an offer of id 7.
        core_ex_trap_ready = 1'b0;
        irq_i = 8'h80;
        step(4);
        chk("t7_valid", 32'(core_ex_trap_valid), 1);
        chk("t7_id", 32'(trap_id_o), 7);
        rst = 1'b1;
        irq_i = 8'h00;
        step(1);
        chk("t7_rst_valid", 32'(core_ex_trap_valid), 0);
        chk("t7_rst_pend", 32'(pending_o), 32'h00);
        chk("t7_rst_lost", 32'(lost_o), 0);
        chk("t7_rst_id", 32'(trap_id_o), 0);
        rst = 1'b0;
        core_ex_trap_ready = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (core_ex_trap_valid) cnt++;
        end
        chk("t7_no_req", 32'(cnt), 0);

        // Line high across reset release yields exactly one request.
        irq_i = 8'h08;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(4);
        chk("t8_valid", 32'(core_ex_trap_valid), 1);
        chk("t8_id", 32'(trap_id_o), 3);
        cnt = 1;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (core_ex_trap_valid) cnt++;
        end
        chk("t8_one_req", 32'(cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
